// File: rtl/dmi_jtag_host_pkg.sv
// Shared types for the DMI JTAG host: request opcodes, sequencer states, TMS sequence lengths.
// No logic here beyond opcode decode.
// Opcode 3 folds onto TapReset.
package dmi_jtag_host_pkg;

   typedef enum logic [1:0] {
      DrScan   = 2'd0,
      IrScan   = 2'd1,
      TapReset = 2'd2
   } op_e;

   typedef enum logic [2:0] {
      Init, Idle, Header, Shift, Trailer, RunIdle, Respond
   } state_e;

   localparam int unsigned InitEdges    = 6;
   localparam int unsigned DrHdrEdges   = 3;
   localparam int unsigned IrHdrEdges   = 4;
   localparam int unsigned TrailerEdges = 2;

   function automatic op_e decode_op(input logic [1:0] op);
      case (op)
         2'd0:    return DrScan;
         2'd1:    return IrScan;
         default: return TapReset;
      endcase
   endfunction

endpackage

// File: rtl/dmi_jtag_host_tck_gen.sv
// TCK generator: ClkDiv cycles low then ClkDiv cycles high while enabled, low otherwise.
// rise_o marks the last low cycle (TCK rises at its closing edge); fall_o marks the last high cycle.
// No backpressure; dropping en_i restarts the period with TCK low.
module dmi_jtag_host_tck_gen #(
   parameter int unsigned ClkDiv = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic tck_o,
   output logic fall_o,
   output logic rise_o
);

   localparam int unsigned CntW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;

   logic [CntW-1:0] cnt_q;
   logic            phase_q;
   logic            cnt_last;

   assign cnt_last = (cnt_q == CntW'(ClkDiv - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i || !en_i) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (cnt_last) begin
         cnt_q   <= '0;
         phase_q <= !phase_q;
      end else begin
         cnt_q   <= cnt_q + 1'b1;
      end
   end

   assign tck_o  = en_i & phase_q;
   assign rise_o = en_i & !phase_q & cnt_last;
   assign fall_o = en_i & phase_q & cnt_last;

endmodule

// File: rtl/dmi_jtag_host.sv
// JTAG initiator running full IR/DR scans and TAP resets against a DTM TAP.
// Response valid N*2*ClkDiv+1 cycles after the request handshake (N = TCK edges of the sequence).
// One request in flight; a stalled response holds the block in Respond with TCK parked low.
module dmi_jtag_host
   import dmi_jtag_host_pkg::*;
#(
   parameter int unsigned ClkDiv     = 2,
   parameter int unsigned MaxLen     = 41,
   parameter int unsigned IdleCycles = 1,
   parameter int unsigned LenW       = $clog2(MaxLen + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_op_i,
   input  logic [LenW-1:0]   req_len_i,
   input  logic [MaxLen-1:0] req_data_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [MaxLen-1:0] rsp_data_o,
   output logic              tck_o,
   output logic              tms_o,
   output logic              tdi_o,
   input  logic              tdo_i,
   output logic              busy_o
);

   localparam int unsigned EdgeW = $clog2(MaxLen + 8);

   state_e            state_q, state_d;
   op_e               op_q;
   logic [LenW-1:0]   len_q, req_len_c;
   logic [MaxLen-1:0] sr_q, rsp_q;
   logic [EdgeW-1:0]  edge_q, edge_d, state_edges;
   logic              tms_q, tdi_q, tms_nx;
   logic              init_rsp_q;
   logic              tck_en, fall, rise, req_hs;

   assign req_hs = req_valid_i && req_ready_o;
   assign tck_en = !rst_i && !(state_q inside {Idle, Respond});

   dmi_jtag_host_tck_gen #(.ClkDiv(ClkDiv)) u_tck_gen (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (tck_en),
      .tck_o  (tck_o),
      .fall_o (fall),
      .rise_o (rise)
   );

   always_comb begin
      req_len_c = req_len_i;
      if (req_len_i == '0) begin
         req_len_c = LenW'(1);
      end else if (req_len_i > LenW'(MaxLen)) begin
         req_len_c = LenW'(MaxLen);
      end
   end

   always_comb begin
      state_edges = '0;
      case (state_q)
         Init:    state_edges = EdgeW'(InitEdges);
         Header:  state_edges = (op_q == IrScan) ? EdgeW'(IrHdrEdges) : EdgeW'(DrHdrEdges);
         Shift:   state_edges = EdgeW'(len_q);
         Trailer: state_edges = EdgeW'(TrailerEdges);
         RunIdle: state_edges = EdgeW'(IdleCycles);
         default: state_edges = '0;
      endcase
   end

   // edge_q counts completed edges of the current state; states change only at period end
   always_comb begin
      state_d = state_q;
      edge_d  = edge_q;
      case (state_q)
         Idle: begin
            if (req_hs) begin
               state_d = (decode_op(req_op_i) == TapReset) ? Init : Header;
               edge_d  = '0;
            end
         end
         Respond: begin
            if (rsp_ready_i) begin
               state_d = Idle;
            end
         end
         default: begin
            if (fall && edge_q == state_edges) begin
               edge_d = '0;
               case (state_q)
                  Init:    state_d = init_rsp_q ? Respond : Idle;
                  Header:  state_d = Shift;
                  Shift:   state_d = Trailer;
                  Trailer: state_d = (IdleCycles == 0) ? Respond : RunIdle;
                  default: state_d = Respond;
               endcase
            end else if (rise) begin
               edge_d = edge_q + 1'b1;
            end
         end
      endcase
   end

   // TMS for the period about to start, indexed by the next state and its edge number
   always_comb begin
      tms_nx = 1'b0;
      case (state_d)
         Init:    tms_nx = (edge_d < EdgeW'(InitEdges - 1));
         Header:  tms_nx = (op_q == IrScan) ? (edge_d < EdgeW'(2)) : (edge_d == '0);
         Shift:   tms_nx = (edge_d == EdgeW'(len_q) - 1'b1);
         Trailer: tms_nx = (edge_d == '0);
         default: tms_nx = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= Init;
         edge_q     <= '0;
         op_q       <= DrScan;
         len_q      <= LenW'(1);
         sr_q       <= '0;
         rsp_q      <= '0;
         tms_q      <= 1'b1;
         tdi_q      <= 1'b0;
         init_rsp_q <= 1'b0;
      end else begin
         state_q <= state_d;
         edge_q  <= edge_d;
         if (req_hs) begin
            op_q       <= decode_op(req_op_i);
            len_q      <= req_len_c;
            sr_q       <= req_data_i;
            rsp_q      <= '0;
            init_rsp_q <= (decode_op(req_op_i) == TapReset);
         end
         if (rise && state_q == Shift) begin
            rsp_q[edge_q] <= tdo_i;
            sr_q          <= sr_q >> 1;
         end
         if (fall || req_hs) begin
            tms_q <= tms_nx;
            tdi_q <= (state_d == Shift) ? sr_q[0] : 1'b0;
         end
      end
   end

   assign req_ready_o = !rst_i && (state_q == Idle);
   assign rsp_valid_o = !rst_i && (state_q == Respond);
   assign rsp_data_o  = rst_i ? '0 : rsp_q;
   assign tms_o       = tms_q | rst_i;
   assign tdi_o       = tdi_q & !rst_i;
   assign busy_o      = rst_i || !(state_q inside {Idle, Respond});

endmodule

// File: tb/tb_dmi_jtag_host.sv
// Bench for dmi_jtag_host against a behavioural DTM TAP (IrLength 5, IDCODE 1, DTMCS 0x1071, bypass).
module tb_dmi_jtag_host;

   localparam int unsigned ClkDiv     = 2;
   localparam int unsigned MaxLen     = 41;
   localparam int unsigned IdleCycles = 1;
   localparam int unsigned LenW       = $clog2(MaxLen + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [1:0]        req_op = 2'd0;
   logic [LenW-1:0]   req_len = '0;
   logic [MaxLen-1:0] req_data = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [MaxLen-1:0] rsp_data;
   logic              tck, tms, tdi, busy;
   logic              tdo = 1'b0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int hs_cyc = 0;
   int tck_edges = 0;
   logic saw_valid = 1'b0;
   logic tms_log[$];

   typedef struct {
      logic [63:0] data;
      int          lat;
      int          edges;
   } exp_t;
   exp_t sb[$];

   dmi_jtag_host #(
      .ClkDiv(ClkDiv), .MaxLen(MaxLen), .IdleCycles(IdleCycles), .LenW(LenW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_op_i    (req_op),
      .req_len_i   (req_len),
      .req_data_i  (req_data),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .tck_o       (tck),
      .tms_o       (tms),
      .tdi_o       (tdi),
      .tdo_i       (tdo),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) if (rsp_valid === 1'b1) saw_valid = 1'b1;

   // behavioural TAP
   typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUDR, EX2DR, UPDR,
                     SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPIR} tap_e;
   tap_e        ts = TLR;
   logic [4:0]  ir = 5'h01;
   logic [4:0]  irsr = 5'h00;
   logic [63:0] dr = 64'h0;
   int          dr_len = 1;

   function automatic tap_e tap_next(input tap_e s, input logic m);
      case (s)
         TLR:   return m ? TLR   : RTI;
         RTI:   return m ? SELDR : RTI;
         SELDR: return m ? SELIR : CAPDR;
         CAPDR: return m ? EX1DR : SHDR;
         SHDR:  return m ? EX1DR : SHDR;
         EX1DR: return m ? UPDR  : PAUDR;
         PAUDR: return m ? EX2DR : PAUDR;
         EX2DR: return m ? UPDR  : SHDR;
         UPDR:  return m ? SELDR : RTI;
         SELIR: return m ? TLR   : CAPIR;
         CAPIR: return m ? EX1IR : SHIR;
         SHIR:  return m ? EX1IR : SHIR;
         EX1IR: return m ? UPIR  : PAUIR;
         PAUIR: return m ? EX2IR : PAUIR;
         EX2IR: return m ? UPIR  : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction

   always @(posedge tck) begin
      case (ts)
         CAPDR: begin
            if (ir == 5'h01) begin dr = 64'h1; dr_len = 32; end
            else if (ir == 5'h10) begin dr = 64'h1071; dr_len = 32; end
            else begin dr = 64'h0; dr_len = 1; end
         end
         SHDR: begin dr = dr >> 1; dr[dr_len-1] = tdi; end
         CAPIR: irsr = 5'b00101;
         SHIR:  irsr = {tdi, irsr[4:1]};
         UPIR:  ir = irsr;
         default: ;
      endcase
      ts = tap_next(ts, tms);
      if (ts == TLR) ir = 5'h01;
      tck_edges++;
      tms_log.push_back(tms);
   end

   always @(negedge tck) tdo = (ts == SHDR) ? dr[0] : (ts == SHIR) ? irsr[0] : 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] pack_log();
      logic [63:0] v = 64'h0;
      for (int i = 0; i < tms_log.size() && i < 64; i++) v[i] = tms_log[i];
      return v;
   endfunction

   task automatic issue(input logic [1:0] op, input int len, input logic [63:0] data);
      int n = 0;
      @(negedge clk);
      req_op = op; req_len = LenW'(len); req_data = MaxLen'(data); req_valid = 1'b1;
      while (req_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      check("req_accept", 64'(req_ready), 64'd1);
      hs_cyc = cyc; tck_edges = 0; tms_log.delete(); saw_valid = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic await_rsp(input string tag, input int hold);
      exp_t e;
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
      e = sb.pop_front();
      check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
      if (rsp_valid === 1'b1) begin
         check({tag, "_data"}, 64'(rsp_data), e.data);
         check({tag, "_latency"}, 64'(cyc - hs_cyc), 64'(e.lat));
         check({tag, "_edges"}, 64'(tck_edges), 64'(e.edges));
         check({tag, "_busy"}, 64'(busy), 64'd0);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_stall_ctl"}, 64'({rsp_valid, req_ready, tck, busy}), 64'(4'b1000));
            check({tag, "_stall_data"}, 64'(rsp_data), e.data);
         end
         rsp_ready = 1'b1;
         check({tag, "_no_req_ready"}, 64'(req_ready), 64'd0);
         @(negedge clk);
         rsp_ready = 1'b0;
         check({tag, "_valid_drop"}, 64'({rsp_valid, req_ready}), 64'(2'b01));
      end
   endtask

   task automatic scan(input string tag, input logic [1:0] op, input int len,
                       input logic [63:0] data, input logic [63:0] exp_data,
                       input int edges, input int hold);
      exp_t e;
      e.data = exp_data; e.lat = edges * 2 * ClkDiv + 1; e.edges = edges;
      sb.push_back(e);
      issue(op, len, data);
      await_rsp(tag, hold);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (req_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      check({tag, "_ready"}, 64'(req_ready), 64'd1);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ctl", 64'({tck, tms, tdi, req_ready, rsp_valid, busy}), 64'(6'b010001));
      check("rst_data", 64'(rsp_data), 64'd0);
      rst = 1'b0;
      tms_log.delete();
      wait_ready("init");
      check("init_tms", pack_log(), 64'h1f);
      check("init_len", 64'(tms_log.size()), 64'd6);
      check("idle_tck", 64'({tck, busy}), 64'd0);

      scan("idcode", 2'd0, 32, 64'h0, 64'h1, 38, 0);
      scan("ir_dtmcs", 2'd1, 5, 64'h10, 64'h05, 12, 0);
      scan("dtmcs", 2'd0, 32, 64'h0, 64'h1071, 38, 0);
      scan("ir_bypass", 2'd1, 5, 64'h1f, 64'h05, 12, 0);
      scan("bypass", 2'd0, 8, 64'hA5, 64'h4A, 14, 0);
      scan("stall", 2'd0, 8, 64'h3C, 64'h78, 14, 50);

      scan("op3_reset", 2'd3, 8, 64'hFF, 64'h0, 6, 0);
      scan("after_op3", 2'd0, 32, 64'h0, 64'h1, 38, 0);
      scan("ir_bypass2", 2'd1, 5, 64'h1f, 64'h05, 12, 0);
      scan("op2_reset", 2'd2, 0, 64'h0, 64'h0, 6, 0);
      scan("after_op2", 2'd0, 32, 64'h0, 64'h1, 38, 0);

      scan("len0", 2'd0, 0, 64'h0, 64'h1, 7, 0);
      check("len0_tms", pack_log(), 64'h19);
      scan("len63", 2'd0, 63, 64'h1AB, 64'h1AB_0000_0001, 47, 0);

      issue(2'd0, 32, 64'h0);
      repeat (20) @(negedge clk);
      check("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_ctl", 64'({tck, tms, tdi, req_ready, rsp_valid, busy}), 64'(6'b010001));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tms_log.delete();
      wait_ready("reinit");
      check("reinit_tms", pack_log(), 64'h1f);
      check("reinit_len", 64'(tms_log.size()), 64'd6);
      check("abort_no_rsp", 64'(saw_valid), 64'd0);
      scan("after_abort", 2'd0, 32, 64'h0, 64'h1, 38, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
